// File: rtl/cnt_arbiter.sv
// cnt_arbiter: round-robin arbiter/sequencer sharing one event-counter datapath between NREQ requesters.
// Ports: Clk/Reset (async active-low); Req/ReqSlt per-requester request and mode; ClrReq clear request;
//        Gnt one-hot grant, CntEn/CntSlt/CntClr counter controls, Busy high while clearing. All outputs registered.
// Latency Req->Gnt 1 cycle; a clear holds CntClr CLR_HOLD cycles and outranks all count requests.
// Optional macro CNT_ARB_PRIO0_EN: requester 0 gets fixed top priority, the rest rotate round-robin.
module cnt_arbiter #(
  parameter int NREQ     = 4,
  parameter int CLR_HOLD = 2
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic [NREQ-1:0] Req,
  input  logic [NREQ-1:0] ReqSlt,
  input  logic            ClrReq,
  output logic [NREQ-1:0] Gnt,
  output logic            CntEn,
  output logic            CntSlt,
  output logic            CntClr,
  output logic            Busy
);

  localparam int LW = $clog2(NREQ);
  // A hold of one cycle needs no counting, but keep at least one counter bit.
  localparam int CW = (CLR_HOLD > 1) ? $clog2(CLR_HOLD) : 1;
  localparam logic [CW-1:0] CLR_LOAD = CW'(CLR_HOLD - 1);
  localparam logic [LW-1:0] LAST_RST = LW'(NREQ - 1);
  localparam logic [LW:0]   NREQ_W   = (LW+1)'(NREQ);

  typedef enum logic {
    ST_ARB   = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   clr_cnt_q, clr_cnt_d;
  logic [LW-1:0]   last_q, last_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic            cnt_en_q, cnt_en_d;
  logic            cnt_slt_q, cnt_slt_d;

  logic [NREQ-1:0] req_cand;
  logic            win_vld;
  logic [LW-1:0]   win_idx;
  logic [LW:0]     sum;

  // Winner search: first set request starting one past the last winner, wrapping.
  always_comb begin
    req_cand = Req;
    win_vld  = 1'b0;
    win_idx  = '0;
    sum      = '0;
`ifdef CNT_ARB_PRIO0_EN
    // Requester 0 is handled outside the rotation.
    req_cand[0] = 1'b0;
`endif
    for (int i = 1; i <= NREQ; i++) begin
      sum = {1'b0, last_q} + (LW+1)'(i);
      if (sum >= NREQ_W) sum = sum - NREQ_W;
      if (!win_vld && req_cand[sum[LW-1:0]]) begin
        win_vld = 1'b1;
        win_idx = sum[LW-1:0];
      end
    end
`ifdef CNT_ARB_PRIO0_EN
    if (Req[0]) begin
      win_vld = 1'b1;
      win_idx = '0;
    end
`endif
  end

  // Next state and registered outputs.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    last_d    = last_q;
    gnt_d     = '0;
    cnt_en_d  = 1'b0;
    cnt_slt_d = 1'b0;
    if (state_q == ST_CLEAR && clr_cnt_q != '0) begin
      clr_cnt_d = clr_cnt_q - CW'(1);
    end else if (ClrReq) begin
      // Also covers the last CLEAR cycle: a still-high ClrReq restarts with no gap.
      state_d   = ST_CLEAR;
      clr_cnt_d = CLR_LOAD;
    end else begin
      // Arbitration runs in ARB and on the edge that ends a clear.
      state_d = ST_ARB;
      if (win_vld) begin
        gnt_d[win_idx] = 1'b1;
        cnt_en_d       = 1'b1;
        cnt_slt_d      = ReqSlt[win_idx];
`ifdef CNT_ARB_PRIO0_EN
        if (win_idx != '0) last_d = win_idx;
`else
        last_d = win_idx;
`endif
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q   <= ST_ARB;
      clr_cnt_q <= '0;
      last_q    <= LAST_RST;
      gnt_q     <= '0;
      cnt_en_q  <= 1'b0;
      cnt_slt_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      last_q    <= last_d;
      gnt_q     <= gnt_d;
      cnt_en_q  <= cnt_en_d;
      cnt_slt_q <= cnt_slt_d;
    end
  end

  assign Gnt    = gnt_q;
  assign CntEn  = cnt_en_q;
  assign CntSlt = cnt_slt_q;
  assign CntClr = (state_q == ST_CLEAR);
  assign Busy   = (state_q == ST_CLEAR);

endmodule

// File: tb/tb_cnt_arbiter.sv
// tb_cnt_arbiter: self-checking bench for cnt_arbiter with a cycle-level reference model.
// Inputs change 1 ns after a rising edge; outputs are compared 1 ns after the edge.
// Directed scenarios plus a randomized run; one summary line at the end.
module tb_cnt_arbiter;
  localparam int NREQ     = 4;
  localparam int CLR_HOLD = 2;
  localparam int VW       = NREQ + 4;

  logic            Clk = 1'b0;
  logic            Reset = 1'b1;
  logic [NREQ-1:0] Req = '0;
  logic [NREQ-1:0] ReqSlt = '0;
  logic            ClrReq = 1'b0;
  logic [NREQ-1:0] Gnt;
  logic            CntEn, CntSlt, CntClr, Busy;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: mode (0 arbitrating, 1 clearing), remaining extra clear cycles, last winner.
  int              m_clearing;
  int              m_left;
  int              m_last;
  logic [NREQ-1:0] e_gnt;
  logic            e_en, e_slt, e_clr, e_busy;

  cnt_arbiter #(.NREQ(NREQ), .CLR_HOLD(CLR_HOLD)) dut (
    .Clk(Clk), .Reset(Reset), .Req(Req), .ReqSlt(ReqSlt), .ClrReq(ClrReq),
    .Gnt(Gnt), .CntEn(CntEn), .CntSlt(CntSlt), .CntClr(CntClr), .Busy(Busy)
  );

  always #5 Clk = ~Clk;

  function automatic int pick_winner(logic [NREQ-1:0] r, int last);
    logic [NREQ-1:0] rr;
`ifdef CNT_ARB_PRIO0_EN
    if (r[0]) return 0;
    r[0] = 1'b0;
`endif
    for (int k = 1; k <= NREQ; k++) begin
      int c = (last + k) % NREQ;
      rr = r >> c;
      if (rr[0]) return c;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_clearing = 0; m_left = 0; m_last = NREQ - 1;
    e_gnt = '0; e_en = 0; e_slt = 0; e_clr = 0; e_busy = 0;
  endtask

  task automatic model_edge();
    int w;
    logic [NREQ-1:0] s;
    w = -1;
    if (m_clearing == 1 && m_left > 0) begin
      m_left = m_left - 1;
    end else if (ClrReq) begin
      m_clearing = 1;
      m_left = CLR_HOLD - 1;
    end else begin
      m_clearing = 0;
      w = pick_winner(Req, m_last);
`ifdef CNT_ARB_PRIO0_EN
      if (w > 0) m_last = w;
`else
      if (w >= 0) m_last = w;
`endif
    end
    e_clr  = (m_clearing == 1);
    e_busy = (m_clearing == 1);
    e_gnt  = (w >= 0) ? (NREQ'(1) << w) : '0;
    e_en   = (w >= 0);
    s      = (w >= 0) ? (ReqSlt >> w) : '0;
    e_slt  = s[0];
  endtask

  function automatic logic [VW-1:0] exp_vec();
    return {e_gnt, e_en, e_slt, e_clr, e_busy};
  endfunction

  // One clock: DUT samples current inputs, model follows, then settle before comparing.
  task automatic step();
    @(posedge Clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    Reset = 1'b0;
    #1;
    model_reset();
    Reset = 1'b1;
  endtask

  task automatic test_reset();
    #2 Reset = 1'b0;
    #1;
    model_reset();
    n_tests++;
    if ({Gnt, CntEn, CntSlt, CntClr, Busy} !== '0)
      begin n_fail++; $display("FAIL reset_initial: got %b want 0", {Gnt, CntEn, CntSlt, CntClr, Busy}); end
    @(posedge Clk); #1;
    Reset = 1'b1;
    Req = 4'b1111; ReqSlt = 4'b0000;
    repeat (3) step();
    // Mid-run asynchronous reset must clear outputs without a clock edge.
    #2 Reset = 1'b0;
    #1;
    n_tests++;
    if ({Gnt, CntEn, CntSlt, CntClr, Busy} !== '0)
      begin n_fail++; $display("FAIL reset_async: got %b want 0", {Gnt, CntEn, CntSlt, CntClr, Busy}); end
    repeat (2) @(posedge Clk);
    #1;
    n_tests++;
    if ({Gnt, CntEn, CntSlt, CntClr, Busy} !== '0)
      begin n_fail++; $display("FAIL reset_held: got %b want 0", {Gnt, CntEn, CntSlt, CntClr, Busy}); end
    model_reset();
    Reset = 1'b1;
    step();
    n_tests++;
    if (Gnt !== 4'b0001 || CntEn !== 1'b1)
      begin n_fail++; $display("FAIL reset_first_grant: got gnt=%b en=%b want gnt=0001 en=1", Gnt, CntEn); end
  endtask

  task automatic test_rotation();
    logic [NREQ-1:0] want_gnt [5];
    logic            want_slt [5];
`ifdef CNT_ARB_PRIO0_EN
    want_gnt = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
    want_slt = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
`else
    want_gnt = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    want_slt = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
`endif
    do_reset();
    Req = 4'b1111; ReqSlt = 4'b1010; ClrReq = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      n_tests++;
      if (Gnt !== want_gnt[i] || CntSlt !== want_slt[i] || CntEn !== 1'b1 || CntClr !== 1'b0)
        begin n_fail++; $display("FAIL rotation[%0d]: got gnt=%b slt=%b en=%b clr=%b want gnt=%b slt=%b en=1 clr=0",
                                  i, Gnt, CntSlt, CntEn, CntClr, want_gnt[i], want_slt[i]); end
    end
  endtask

  task automatic test_single();
    do_reset();
    Req = 4'b0100; ReqSlt = 4'b0100; ClrReq = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      n_tests++;
      if (Gnt !== 4'b0100 || CntSlt !== 1'b1 || CntEn !== 1'b1)
        begin n_fail++; $display("FAIL single[%0d]: got gnt=%b slt=%b en=%b want 0100/1/1", i, Gnt, CntSlt, CntEn); end
    end
  endtask

  task automatic test_clear_pulse();
    do_reset();
    Req = 4'b0011; ReqSlt = 4'b0000; ClrReq = 1'b1;
    step();
    ClrReq = 1'b0;
    n_tests++;
    if (CntClr !== 1'b1 || Busy !== 1'b1 || Gnt !== '0 || CntEn !== 1'b0)
      begin n_fail++; $display("FAIL clear_pulse_c1: got clr=%b busy=%b gnt=%b en=%b want 1/1/0000/0", CntClr, Busy, Gnt, CntEn); end
    step();
    n_tests++;
    if (CntClr !== 1'b1 || Busy !== 1'b1 || Gnt !== '0 || CntEn !== 1'b0)
      begin n_fail++; $display("FAIL clear_pulse_c2: got clr=%b busy=%b gnt=%b en=%b want 1/1/0000/0", CntClr, Busy, Gnt, CntEn); end
    step();
    n_tests++;
    if (CntClr !== 1'b0 || Busy !== 1'b0 || Gnt !== 4'b0001 || CntEn !== 1'b1)
      begin n_fail++; $display("FAIL clear_pulse_resume: got clr=%b busy=%b gnt=%b en=%b want 0/0/0001/1", CntClr, Busy, Gnt, CntEn); end
    step();
    n_tests++;
    if ({Gnt, CntEn, CntSlt, CntClr, Busy} !== exp_vec())
      begin n_fail++; $display("FAIL clear_pulse_next: got %b want %b", {Gnt, CntEn, CntSlt, CntClr, Busy}, exp_vec()); end
  endtask

  task automatic test_clear_hold();
    int clr_cycles;
    int gnt_during;
    clr_cycles = 0; gnt_during = 0;
    do_reset();
    Req = 4'b1111; ReqSlt = 4'b0000;
    for (int i = 0; i < 9; i++) begin
      ClrReq = (i < 5);
      step();
      if (CntClr === 1'b1) begin
        clr_cycles++;
        if (Gnt !== '0 || CntEn !== 1'b0) gnt_during++;
      end
    end
    n_tests++;
    if (clr_cycles !== 6)
      begin n_fail++; $display("FAIL clear_hold_len: got %0d clear cycles want 6", clr_cycles); end
    n_tests++;
    if (gnt_during !== 0)
      begin n_fail++; $display("FAIL clear_hold_gnt: got %0d grant cycles during clear want 0", gnt_during); end
    n_tests++;
    if (Gnt === '0 || CntClr !== 1'b0)
      begin n_fail++; $display("FAIL clear_hold_after: got gnt=%b clr=%b want a grant and clr=0", Gnt, CntClr); end
  endtask

  task automatic test_prio0();
    do_reset();
    ClrReq = 1'b0; ReqSlt = 4'b0101;
    Req = 4'b1110;
    step();
    Req = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      step();
      n_tests++;
      if ({Gnt, CntEn, CntSlt, CntClr, Busy} !== exp_vec())
        begin n_fail++; $display("FAIL prio0[%0d]: got %b want %b", i, {Gnt, CntEn, CntSlt, CntClr, Busy}, exp_vec()); end
`ifdef CNT_ARB_PRIO0_EN
      n_tests++;
      if (Gnt !== 4'b0001)
        begin n_fail++; $display("FAIL prio0_fixed[%0d]: got gnt=%b want 0001", i, Gnt); end
`endif
    end
    Req = 4'b1110;
    for (int i = 0; i < 3; i++) begin
      step();
      n_tests++;
      if ({Gnt, CntEn, CntSlt, CntClr, Busy} !== exp_vec())
        begin n_fail++; $display("FAIL prio0_drop[%0d]: got %b want %b", i, {Gnt, CntEn, CntSlt, CntClr, Busy}, exp_vec()); end
    end
  endtask

  task automatic test_random();
    int bad_cycles;
    int bad_inv;
    bad_cycles = 0; bad_inv = 0;
    do_reset();
    for (int i = 0; i < 500; i++) begin
      Req    = NREQ'($urandom);
      ReqSlt = NREQ'($urandom);
      ClrReq = ($urandom_range(0, 9) == 0);
      step();
      if ({Gnt, CntEn, CntSlt, CntClr, Busy} !== exp_vec()) begin
        bad_cycles++;
        if (bad_cycles <= 5)
          $display("FAIL random_cycle[%0d]: got %b want %b", i, {Gnt, CntEn, CntSlt, CntClr, Busy}, exp_vec());
      end
      if (!$onehot0(Gnt) || CntEn !== (|Gnt) || (CntEn && CntClr)) bad_inv++;
    end
    n_tests++;
    if (bad_cycles !== 0)
      begin n_fail++; $display("FAIL random_model: got %0d mismatching cycles want 0", bad_cycles); end
    n_tests++;
    if (bad_inv !== 0)
      begin n_fail++; $display("FAIL random_invariants: got %0d violating cycles want 0", bad_inv); end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_rotation();
    test_single();
    test_clear_pulse();
    test_clear_hold();
    test_prio0();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
